// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-addressable data RAM with LED register, cycle counter and a store-driven pass/fail monitor.
module dmem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] LED_ADDR  = 32'h0000_7F00,
  parameter logic [31:0] CYC_ADDR  = 32'h0000_7F04,
  parameter logic [31:0] PASS_ADDR = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd25,
  parameter logic [31:0] SKIP_ADDR = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        LoadUnsigned,
  output logic [31:0] ReadData,
  output logic [7:0]  led,
  output logic        done,
  output logic        pass,
  output logic        misalign
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {RUN, PASSED, FAILED} state_t;

  logic [31:0] mem [DEPTH];
  state_t      state_q, state_d;
  logic [31:0] cyc_q;
  logic [7:0]  led_q;
  logic        done_q, pass_q, mis_q;

  logic        sz_b, sz_h, sz_w, aligned, in_ram, is_led, is_cyc, mapped;
  logic        we_ram, we_led;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  logic [31:0] wdat, word_adr, rdw, sh;

  assign sz_b     = Size == 2'b00;
  assign sz_h     = Size == 2'b01;
  assign sz_w     = Size[1];
  assign aligned  = sz_b | (sz_h & ~DataAdr[0]) | (sz_w & (DataAdr[1:0] == 2'b00));
  assign word_adr = {DataAdr[31:2], 2'b00};
  assign in_ram   = DataAdr < RAM_BYTES;
  assign is_led   = word_adr == LED_ADDR;
  assign is_cyc   = word_adr == CYC_ADDR;
  assign mapped   = in_ram | is_led | is_cyc;
  assign idx      = DataAdr[AW+1:2];
  assign mask     = sz_b ? 4'b0001 << DataAdr[1:0] : sz_h ? (DataAdr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdat     = sz_b ? {4{WriteData[7:0]}} : sz_h ? {2{WriteData[15:0]}} : WriteData;
  assign we_ram   = MemWrite & aligned & in_ram;
  assign we_led   = MemWrite & aligned & is_led;

  // Load path: pick the addressed word, shift the selected lane down, then extend.
  assign rdw      = in_ram ? mem[idx] : is_led ? {24'h0, led_q} : is_cyc ? cyc_q : 32'h0;
  assign sh       = rdw >> {DataAdr[1:0], 3'b000};
  assign ReadData = !(aligned && mapped) ? 32'h0 :
                    sz_b ? {{24{~LoadUnsigned & sh[7]}}, sh[7:0]} :
                    sz_h ? {{16{~LoadUnsigned & sh[15]}}, sh[15:0]} : sh;

  // RAM has no reset so its contents survive it; stores are still gated while reset is low.
  always_ff @(posedge clk)
    if (reset && we_ram)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && MemWrite)
      state_d = (DataAdr == PASS_ADDR && WriteData == PASS_DATA) ? PASSED :
                (DataAdr != SKIP_ADDR) ? FAILED : RUN;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RUN;
      cyc_q   <= 32'h0;
      led_q   <= 8'h0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= state_q == RUN ? cyc_q + 32'd1 : cyc_q;
      led_q   <= (we_led && mask[0]) ? wdat[7:0] : led_q;
      done_q  <= state_d != RUN;
      pass_q  <= state_d == PASSED;
      mis_q   <= mis_q | (MemWrite & ~aligned);
    end

  assign led      = led_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign misalign = mis_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: table-driven checks of loads/stores, MMIO, monitor and reset behaviour of dmem_mmio.
module tb_dmem_mmio;
  localparam logic [31:0] LED = 32'h0000_7F00;
  localparam logic [31:0] CYC = 32'h0000_7F04;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [1:0]  Size = 2'b10;
  logic        LoadUnsigned = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic        done, pass, misalign;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        lu;
    logic        chk;
    logic [31:0] rd;
    logic [7:0]  led;
    logic        done;
    logic        pass;
    logic        mis;
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];

  dmem_mmio dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .Size(Size), .LoadUnsigned(LoadUnsigned),
    .ReadData(ReadData), .led(led), .done(done), .pass(pass), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic lu, input logic chk, input logic [31:0] rd,
                              input logic [7:0] l, input logic d, input logic p, input logic m);
    mk = '{we, adr, wd, sz, lu, chk, rd, l, d, p, m};
  endfunction

  // Drives one vector at a negedge, checks just after, then advances to the next negedge.
  task automatic apply(input string tag, input int i, input vec_t v);
    MemWrite = v.we; DataAdr = v.adr; WriteData = v.wd; Size = v.sz; LoadUnsigned = v.lu;
    #1;
    if (v.chk) cmp($sformatf("%s[%0d].rd", tag, i), ReadData, v.rd);
    cmp($sformatf("%s[%0d].led", tag, i), {24'h0, led}, {24'h0, v.led});
    cmp($sformatf("%s[%0d].done", tag, i), {31'h0, done}, {31'h0, v.done});
    cmp($sformatf("%s[%0d].pass", tag, i), {31'h0, pass}, {31'h0, v.pass});
    cmp($sformatf("%s[%0d].mis", tag, i), {31'h0, misalign}, {31'h0, v.mis});
    @(negedge clk);
  endtask

  initial begin
    // Skip-store, pass store, then RAM/LED/unmapped/misaligned checks with the monitor in PASS.
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd0, 8'h00, 0, 0, 0));
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd1, 8'h00, 0, 0, 0));
    ta.push_back(mk(1, 96, 32'h1111_2222, 2, 0, 0, 0, 8'h00, 0, 0, 0));
    ta.push_back(mk(0, 96, 0, 2, 0, 1, 32'h1111_2222, 8'h00, 0, 0, 0));
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd4, 8'h00, 0, 0, 0));
    ta.push_back(mk(1, 100, 32'd25, 2, 0, 0, 0, 8'h00, 0, 0, 0));
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd6, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd6, 8'h00, 1, 1, 0));
    ta.push_back(mk(1, 8, 32'hDEAD_BEEF, 2, 0, 0, 0, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 9, 0, 0, 0, 1, 32'hFFFF_FFBE, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 9, 0, 0, 1, 1, 32'h0000_00BE, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 10, 0, 1, 0, 1, 32'hFFFF_DEAD, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 8, 0, 1, 1, 1, 32'h0000_BEEF, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 9, 0, 2, 0, 1, 32'h0, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 9, 0, 1, 0, 1, 32'h0, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 11, 0, 3, 0, 1, 32'h0, 8'h00, 1, 1, 0));
    ta.push_back(mk(0, 11, 0, 0, 0, 1, 32'hFFFF_FFDE, 8'h00, 1, 1, 0));
    ta.push_back(mk(1, LED + 1, 32'h0000_A5A5, 1, 0, 0, 0, 8'h00, 1, 1, 0));
    ta.push_back(mk(1, LED, 32'h0000_003C, 0, 0, 1, 32'h0, 8'h00, 1, 1, 1));
    ta.push_back(mk(0, LED, 0, 2, 0, 1, 32'h0000_003C, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 8, 32'h1234_5678, 2, 0, 1, 32'hDEAD_BEEF, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 8, 0, 2, 0, 1, 32'h1234_5678, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 12, 32'h0, 2, 0, 0, 0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 13, 32'h0000_00AA, 0, 0, 0, 0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 14, 32'h0000_BEEF, 1, 0, 1, 32'h0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 12, 0, 2, 0, 1, 32'hBEEF_AA00, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 14, 0, 1, 0, 1, 32'hFFFF_BEEF, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, CYC, 32'h55, 2, 0, 1, 32'd6, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd6, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 256, 32'h99, 2, 0, 1, 32'h0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 252, 32'hA1B2_C3D4, 2, 0, 0, 0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 252, 0, 2, 0, 1, 32'hA1B2_C3D4, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 256, 0, 2, 0, 1, 32'h0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 32, 32'h0, 2, 0, 0, 0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 34, 32'hFFFF_FFFF, 2, 0, 1, 32'h0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 32, 0, 2, 0, 1, 32'h0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(1, 0, 32'hCAFE_F00D, 2, 0, 0, 0, 8'h3C, 1, 1, 1));
    ta.push_back(mk(0, 0, 0, 2, 0, 1, 32'hCAFE_F00D, 8'h3C, 1, 1, 1));
    // After a reset: RAM retained, counter restarts, first store to a non-pass address fails.
    tb.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd0, 8'h00, 0, 0, 0));
    tb.push_back(mk(0, 0, 0, 2, 0, 1, 32'hCAFE_F00D, 8'h00, 0, 0, 0));
    tb.push_back(mk(0, 100, 0, 2, 0, 1, 32'd25, 8'h00, 0, 0, 0));
    tb.push_back(mk(1, 104, 32'd7, 2, 0, 0, 0, 8'h00, 0, 0, 0));
    tb.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd4, 8'h00, 1, 0, 0));
    tb.push_back(mk(0, CYC, 0, 2, 0, 1, 32'd4, 8'h00, 1, 0, 0));
    tb.push_back(mk(1, 100, 32'd25, 2, 0, 0, 0, 8'h00, 1, 0, 0));
    tb.push_back(mk(0, 104, 0, 2, 0, 1, 32'd7, 8'h00, 1, 0, 0));

    repeat (3) @(negedge clk);
    cmp("rst.done", {31'h0, done}, 32'h0);
    cmp("rst.pass", {31'h0, pass}, 32'h0);
    cmp("rst.mis", {31'h0, misalign}, 32'h0);
    cmp("rst.led", {24'h0, led}, 32'h0);
    reset = 1'b1;
    foreach (ta[i]) apply("A", i, ta[i]);

    // Reset asserted mid-store: outputs clear at once and the store must not commit.
    MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'h77; Size = 2'b10;
    reset = 1'b0;
    #1;
    cmp("async.done", {31'h0, done}, 32'h0);
    cmp("async.pass", {31'h0, pass}, 32'h0);
    cmp("async.mis", {31'h0, misalign}, 32'h0);
    cmp("async.led", {24'h0, led}, 32'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    reset = 1'b1;
    foreach (tb[i]) apply("B", i, tb[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
